// File: rtl/bcd_digit_counter_if.sv
// bcd_digit_counter_if: control inputs and BCD/status outputs of one counter digit
interface bcd_digit_counter_if;
    logic       start;
    logic       stop;
    logic       step;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic       tc;
    logic       carry;
    logic       running;
    modport master (
        output start, stop, step, up_dn, load, load_val,
        input  A, B, C, D, tc, carry, running
    );
    modport slave (
        input  start, stop, step, up_dn, load, load_val,
        output A, B, C, D, tc, carry, running
    );
endinterface

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: single BCD digit up/down counter with run/stop FSM, prescaler and carry pulse
module bcd_digit_counter #(
    parameter int DIV       = 4,
    parameter int RESET_VAL = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    bcd_digit_counter_if.slave         io
);
    typedef enum logic {STOPPED, RUNNING} state_e;
    localparam logic [7:0] PRESC_MAX = 8'(DIV - 1);
    localparam logic [3:0] RST_CNT   = 4'(RESET_VAL);
    state_e     state_q, state_d;
    logic [3:0] count_q, count_d, count_adv;
    logic [7:0] presc_q, presc_d;
    logic       carry_q, carry_d;
    logic       adv, wrap;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STOPPED;
            count_q <= RST_CNT;
            presc_q <= 8'd0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            carry_q <= carry_d;
        end
    end
    // load outranks FSM transitions, which outrank advancing; a transition edge never advances
    always_comb begin
        wrap      = io.up_dn ? (count_q == 4'd9) : (count_q == 4'd0);
        count_adv = io.up_dn ? (wrap ? 4'd0 : count_q + 4'd1) : (wrap ? 4'd9 : count_q - 4'd1);
        state_d   = state_q;
        presc_d   = presc_q;
        adv       = 1'b0;
        if (io.load) begin
            presc_d = 8'd0;
        end else if (state_q == STOPPED && io.start && !io.stop) begin
            state_d = RUNNING;
            presc_d = 8'd0;
        end else if (state_q == RUNNING && io.stop) begin
            state_d = STOPPED;
            presc_d = 8'd0;
        end else if (state_q == RUNNING) begin
            adv     = (presc_q == PRESC_MAX);
            presc_d = adv ? 8'd0 : presc_q + 8'd1;
        end else begin
            adv = io.step;
        end
        count_d = io.load ? ((io.load_val <= 4'd9) ? io.load_val : count_q) : (adv ? count_adv : count_q);
        carry_d = adv & wrap;
    end
    assign {io.A, io.B, io.C, io.D} = count_q;
    assign io.tc      = io.up_dn ? (count_q == 4'd9) : (count_q == 4'd0);
    assign io.carry   = carry_q;
    assign io.running = (state_q == RUNNING);
endmodule

// File: tb/tb_bcd_digit_counter.sv
// tb_bcd_digit_counter: directed table plus hand sequences for two counter configurations
module tb_bcd_digit_counter;
    logic clk = 1'b0;
    logic rst, rst2;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    bcd_digit_counter_if bus1 ();
    bcd_digit_counter_if bus2 ();
    bcd_digit_counter #(.DIV(4), .RESET_VAL(0)) dut1 (.clk(clk), .rst(rst), .io(bus1.slave));
    bcd_digit_counter #(.DIV(1), .RESET_VAL(3)) dut2 (.clk(clk), .rst(rst2), .io(bus2.slave));
    logic [3:0] cnt1, cnt2;
    assign cnt1 = {bus1.A, bus1.B, bus1.C, bus1.D};
    assign cnt2 = {bus2.A, bus2.B, bus2.C, bus2.D};
    typedef struct packed {
        logic       start;
        logic       stop;
        logic       step;
        logic       up_dn;
        logic       load;
        logic [3:0] load_val;
        logic [3:0] cnt;
        logic       tc;
        logic       carry;
        logic       run;
    } vec_t;
    vec_t vt [13];
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask
    task automatic drv(input logic st, input logic sp, input logic stp, input logic up, input logic ld, input logic [3:0] v);
        bus1.start = st; bus1.stop = sp; bus1.step = stp;
        bus1.up_dn = up; bus1.load = ld; bus1.load_val = v;
    endtask
    task automatic exp1(input string n, input logic [3:0] c, input logic run, input logic cy);
        chk({n, ".cnt"}, 8'(cnt1), 8'(c));
        chk({n, ".run"}, 8'(bus1.running), 8'(run));
        chk({n, ".carry"}, 8'(bus1.carry), 8'(cy));
    endtask
    initial begin
        vt[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd8, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd7, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd6, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd6, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9,  4'd9, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 4'd0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd8,  4'd8, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd8, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b1, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b0};
        drv(0, 0, 0, 0, 0, 4'd0);
        bus2.start = 0; bus2.stop = 0; bus2.step = 0; bus2.up_dn = 1; bus2.load = 0; bus2.load_val = 4'd0;
        rst = 1; rst2 = 1;
        tick();
        rst = 0; rst2 = 0;
        exp1("reset", 4'd0, 1'b0, 1'b0);
        chk("reset.tc", 8'(bus1.tc), 8'd1);
        for (int i = 0; i < 13; i++) begin
            drv(vt[i].start, vt[i].stop, vt[i].step, vt[i].up_dn, vt[i].load, vt[i].load_val);
            tick();
            exp1($sformatf("vec%0d", i), vt[i].cnt, vt[i].run, vt[i].carry);
            chk($sformatf("vec%0d.tc", i), 8'(bus1.tc), 8'(vt[i].tc));
        end
        drv(1, 0, 0, 1, 0, 4'd0);
        tick();
        drv(0, 0, 0, 1, 0, 4'd0);
        exp1("start", 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp1("prescale_hold", 4'd0, 1'b1, 1'b0);
        end
        tick();
        exp1("first_adv", 4'd1, 1'b1, 1'b0);
        repeat (4) tick();
        exp1("second_adv", 4'd2, 1'b1, 1'b0);
        repeat (2) tick();
        drv(0, 0, 1, 1, 1, 4'd7);
        tick();
        drv(0, 0, 0, 1, 0, 4'd0);
        exp1("load7_run", 4'd7, 1'b1, 1'b0);
        repeat (3) tick();
        exp1("load7_restart", 4'd7, 1'b1, 1'b0);
        tick();
        exp1("load7_adv", 4'd8, 1'b1, 1'b0);
        repeat (4) tick();
        exp1("run_to9", 4'd9, 1'b1, 1'b0);
        chk("run_to9.tc", 8'(bus1.tc), 8'd1);
        repeat (3) tick();
        exp1("hold9", 4'd9, 1'b1, 1'b0);
        tick();
        exp1("wrap_up", 4'd0, 1'b1, 1'b1);
        chk("wrap_up.tc", 8'(bus1.tc), 8'd0);
        tick();
        exp1("carry_clear", 4'd0, 1'b1, 1'b0);
        drv(0, 0, 0, 1, 1, 4'd12);
        tick();
        exp1("load12_run", 4'd0, 1'b1, 1'b0);
        drv(1, 1, 0, 1, 0, 4'd0);
        tick();
        drv(0, 0, 0, 1, 0, 4'd0);
        exp1("start_stop", 4'd0, 1'b0, 1'b0);
        repeat (5) tick();
        exp1("frozen", 4'd0, 1'b0, 1'b0);
        drv(1, 0, 0, 1, 0, 4'd0);
        tick();
        drv(0, 0, 0, 1, 0, 4'd0);
        exp1("resume", 4'd0, 1'b1, 1'b0);
        repeat (4) tick();
        exp1("resume_adv", 4'd1, 1'b1, 1'b0);
        drv(0, 0, 0, 1, 1, 4'd5);
        tick();
        drv(0, 0, 0, 1, 0, 4'd0);
        exp1("load5", 4'd5, 1'b1, 1'b0);
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        exp1("rst_run", 4'd0, 1'b0, 1'b0);
        chk("rst_run.tc", 8'(bus1.tc), 8'd0);
        repeat (4) tick();
        exp1("after_rst", 4'd0, 1'b0, 1'b0);
        chk("d2.reset.cnt", 8'(cnt2), 8'd3);
        chk("d2.reset.run", 8'(bus2.running), 8'd0);
        bus2.start = 1;
        tick();
        bus2.start = 0;
        chk("d2.start.cnt", 8'(cnt2), 8'd3);
        chk("d2.start.run", 8'(bus2.running), 8'd1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("d2.adv%0d.cnt", k), 8'(cnt2), 8'((3 + k) % 10));
            chk($sformatf("d2.adv%0d.carry", k), 8'(bus2.carry), 8'(k == 7));
        end
        repeat (5) tick();
        chk("d2.at5.cnt", 8'(cnt2), 8'd5);
        rst2 = 1;
        tick();
        rst2 = 0;
        chk("d2.rst.cnt", 8'(cnt2), 8'd3);
        chk("d2.rst.run", 8'(bus2.running), 8'd0);
        chk("d2.rst.carry", 8'(bus2.carry), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_digit_counter.md
Name: bcd_digit_counter

Overview:
- Single-digit BCD (0–9) up/down counter that generates the 4-bit BCD code consumed by the BCD-to-decimal decoder stage.
- Outputs A, B, C, D drive the decoder's A, B, C, D inputs directly, one-to-one.
- Two-state run/stop controller with a built-in prescaler, so lab boards can count automatically or single-step.
- Carry/borrow pulse allows cascading digits.

Parameters:
- DIV, default 4: clock cycles between count advances in RUNNING. Legal range 1..255; prescaler width 8 bits.
- RESET_VAL, default 0: count value after reset. Legal range 0..9.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  enter RUNNING; level, sampled each cycle.
- stop  in  1  enter STOPPED; level, sampled each cycle.
- step  in  1  advance count by one while STOPPED; each high cycle gives one advance.
- up_dn  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous parallel load.
- load_val  in  4  value to load; MSB first.
- A  out  1  count bit 3 (weight 8).
- B  out  1  count bit 2 (weight 4).
- C  out  1  count bit 1 (weight 2).
- D  out  1  count bit 0 (weight 1).
- tc  out  1  terminal count, combinational from count and up_dn.
- carry  out  1  registered one-cycle pulse after a wrap.
- running  out  1  1 while the FSM is in RUNNING.

Behaviour:
- Reset (synchronous, highest priority):
  - FSM goes to STOPPED; count = RESET_VAL; prescaler = 0.
  - carry = 0; running = 0.
  - {A,B,C,D} = RESET_VAL.
  - tc follows the rule below (with defaults: 1 if up_dn=0, else 0).
- Priority per cycle: rst > load > FSM transition > count advance.
- load = 1:
  - If load_val ≤ 9: count ← load_val.
  - If load_val is 10..15: count is unchanged.
  - In both cases the prescaler clears to 0, no advance occurs that cycle, carry = 0 next cycle, and the FSM state is unchanged.
- FSM transitions:
  - STOPPED → RUNNING when start=1 and stop=0; prescaler clears to 0.
  - RUNNING → STOPPED when stop=1; stop wins if start and stop are high together.
  - The transition cycle itself never advances the count.
- RUNNING:
  - Prescaler increments every cycle, 0..DIV-1.
  - When prescaler == DIV-1: count advances and prescaler wraps to 0.
  - First advance is DIV cycles after the start edge. DIV=1 advances every cycle after entry.
  - step is ignored.
- STOPPED:
  - Prescaler holds at 0.
  - step=1 advances the count on that edge; step held high advances every cycle.
- Advance rule:
  - up_dn=1: count+1, with 9 → 0 wrap.
  - up_dn=0: count−1, with 0 → 9 wrap.
  - up_dn is sampled on the advancing edge only; it may change freely between advances.
- carry is 1 for exactly the cycle following an edge on which a wrap (9→0 up, or 0→9 down) occurred; 0 otherwise.
- tc = (up_dn & count==9) | (~up_dn & count==0); purely combinational, no latency.
- Invariant: count is always in 0..9; the decoder never sees codes 10–15.
- Reset while RUNNING mid-prescale: everything returns to reset values on that edge; the partial prescale is discarded.

Test Plan:
- Reset with DIV=4, RESET_VAL=0 → {A,B,C,D}=0000, running=0, carry=0. Hold start=1 one cycle → running=1; count reaches 1 exactly 4 cycles later, then 2 after 4 more.
- RUNNING, up_dn=1, from count 8 → 9 with tc=1, then 0; carry=1 for one cycle right after the 9→0 edge, then 0.
- STOPPED, up_dn=0, count=0 → one step pulse gives count=9 and carry pulse; tc=1 at count 0 before the step. Step held 3 cycles from 9 → 6.
- load_val=7 with load=1 while RUNNING mid-prescale → count=7, prescaler restarts (next advance 4 cycles later). load_val=12 → count unchanged.
- start=1 and stop=1 in the same cycle while RUNNING → STOPPED, count frozen. Then start alone → RUNNING resumes.
- Assert rst while RUNNING at count 5 → next edge: count=RESET_VAL, running=0, carry=0. Also repeat with RESET_VAL=3 and DIV=1 (advance every cycle).
